fpu_wb_sequencer: RTL and testbench

Wishbone-slave command sequencer that sits between the Caravel management SoC bus and the FPU core inside the user project wrapper. It holds the operand, rounding-mode and opcode registers, launches one FPU operation per start command with a single-cycle valid pulse, and waits for completion with a timeout guard. It then captures the result and exception flags into read-only registers and raises a level interrupt.

---
 rtl/fpu_wb_sequencer_if.sv | 21 ++
 rtl/fpu_wb_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fpu_wb_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_sequencer_if.sv
// Wishbone classic slave bus between the Caravel management SoC and the FPU sequencer.
interface fpu_wb_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fpu_wb_sequencer.sv
// Wishbone-mapped command sequencer: holds FPU operands/opcode, launches one operation
// per start command, waits for completion with a timeout, and reports result, flags and IRQ.
module fpu_wb_sequencer #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter logic [15:0] TIMEOUT   = 16'd64
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_l,
    fpu_wb_sequencer_if.slave           wb,
    output logic [31:0]                 fpu_a_o,
    output logic [31:0]                 fpu_b_o,
    output logic [31:0]                 fpu_c_o,
    output logic [2:0]                  fpu_rm_o,
    output logic [11:0]                 fpu_op_o,
    output logic                        fpu_valid_o,
    input  logic [31:0]                 fpu_result_i,
    input  logic [4:0]                  fpu_flags_i,
    input  logic                        fpu_done_i,
    output logic                        irq_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic        done_q, done_d, timeout_q, timeout_d;
    logic        irqEn_q, irqEn_d, irq_q, irq_d;
    logic [11:0] op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        req, busy, wr;
    logic [7:0]  offset;

    function automatic logic [31:0] applySel(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    assign offset = wb.wbs_adr_i[7:0];
    assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q
                  & (wb.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign wr     = req & wb.wbs_we_i;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        irqEn_d   = irqEn_q;
        op_d      = op_q;
        rm_d      = rm_q;
        ack_d     = req;
        dat_d     = 32'd0;

        if (req) begin
            case (offset)
                8'h00:   dat_d = a_q;
                8'h04:   dat_d = b_q;
                8'h08:   dat_d = c_q;
                8'h0C:   dat_d = result_q;
                8'h10:   dat_d = {27'd0, flags_q};
                8'h14:   dat_d = {29'd0, timeout_q, done_q, busy};
                8'h18:   dat_d = {31'd0, irqEn_q};
                8'h1C:   dat_d = {20'd0, op_q};
                8'h24:   dat_d = {29'd0, rm_q};
                default: dat_d = 32'd0;
            endcase
        end

        if (wr) begin
            case (offset)
                8'h00: if (!busy) a_d = applySel(a_q, wb.wbs_dat_i, wb.wbs_sel_i);
                8'h04: if (!busy) b_d = applySel(b_q, wb.wbs_dat_i, wb.wbs_sel_i);
                8'h08: if (!busy) c_d = applySel(c_q, wb.wbs_dat_i, wb.wbs_sel_i);
                8'h18: if (wb.wbs_sel_i[0]) begin
                    irqEn_d = wb.wbs_dat_i[0];
                    if (wb.wbs_dat_i[1]) begin
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                8'h1C: if (!busy) begin
                    if (wb.wbs_sel_i[0]) op_d[7:0]  = wb.wbs_dat_i[7:0];
                    if (wb.wbs_sel_i[1]) op_d[11:8] = wb.wbs_dat_i[11:8];
                    if (wb.wbs_sel_i[1] && wb.wbs_dat_i[12]) begin
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        state_d   = ISSUE;
                    end
                end
                8'h24: if (!busy && wb.wbs_sel_i[0]) rm_d = wb.wbs_dat_i[2:0];
                default: ;
            endcase
        end

        // Completion is evaluated after bus writes so it overrides a same-edge W1C.
        case (state_q)
            ISSUE: begin
                cnt_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (fpu_done_i) begin
                    result_d = fpu_result_i;
                    flags_d  = fpu_flags_i;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: ;
        endcase

        irq_d = irqEn_d & (done_d | timeout_d);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            c_q       <= 32'd0;
            result_q  <= 32'd0;
            flags_q   <= 5'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irqEn_q   <= 1'b0;
            irq_q     <= 1'b0;
            op_q      <= 12'd0;
            rm_q      <= 3'd0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            irqEn_q   <= irqEn_d;
            irq_q     <= irq_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign fpu_a_o      = a_q;
    assign fpu_b_o      = b_q;
    assign fpu_c_o      = c_q;
    assign fpu_rm_o     = rm_q;
    assign fpu_op_o     = op_q;
    assign fpu_valid_o  = (state_q == ISSUE);
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
// Directed self-checking bench for fpu_wb_sequencer: register access, launch, completion,
// timeout, busy write blocking, W1C race, and mid-operation reset.
module tb_fpu_wb_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rstL;
    logic [31:0] fpuA, fpuB, fpuC;
    logic [2:0]  fpuRm;
    logic [11:0] fpuOp;
    logic        fpuValid;
    logic [31:0] fpuResult;
    logic [4:0]  fpuFlags;
    logic        fpuDone;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int validCount = 0;

    always #5 clk = ~clk;

    fpu_wb_sequencer_if wb();

    fpu_wb_sequencer #(.ADDR_BASE(BASE), .TIMEOUT(16'd64)) dut (
        .wb_clk_i     (clk),
        .rst_l        (rstL),
        .wb           (wb.slave),
        .fpu_a_o      (fpuA),
        .fpu_b_o      (fpuB),
        .fpu_c_o      (fpuC),
        .fpu_rm_o     (fpuRm),
        .fpu_op_o     (fpuOp),
        .fpu_valid_o  (fpuValid),
        .fpu_result_i (fpuResult),
        .fpu_flags_i  (fpuFlags),
        .fpu_done_i   (fpuDone),
        .irq_o        (irq)
    );

    always @(posedge clk) begin
        if (fpuValid) validCount <= validCount + 1;
    end

    // Bus transfers start and end on the falling edge; each waits a bounded number of cycles for ack.
    task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           output logic acked);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o === 1'b1) acked = 1'b1;
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wbRead(input logic [31:0] adr, output logic [31:0] data, output logic acked);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = adr;
        wb.wbs_sel_i = 4'hF;
        acked = 1'b0;
        data  = 32'hx;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                data  = wb.wbs_dat_o;
            end
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0]  offs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                   8'h18, 8'h1C, 8'h20, 8'h24, 8'h28};
        logic [31:0] rd;
        logic        ok;
        rstL = 1'b0;
        repeat (2) @(negedge clk);
        rstL = 1'b1;
        checks++;
        if (irq !== 1'b0 || fpuValid !== 1'b0 || wb.wbs_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: irq=%b valid=%b ack=%b, required 0 0 0",
                     irq, fpuValid, wb.wbs_ack_o);
        end
        foreach (offs[i]) begin
            wbRead(BASE + {24'd0, offs[i]}, rd, ok);
            checks++;
            if (!ok || rd !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_read_%02h: ack=%b data=%h, required ack=1 data=0",
                         offs[i], ok, rd);
            end
        end
        wbRead(32'h3000_0100, rd, ok);
        checks++;
        if (ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL out_of_range: ack=%b, required no ack", ok);
        end
    endtask

    task automatic test_add();
        logic        ok;
        logic [31:0] rd;
        int          startCount;
        wbWrite(BASE + 32'h00, 32'h3F80_0000, 4'hF, ok);
        wbWrite(BASE + 32'h04, 32'h4000_0000, 4'hF, ok);
        wbWrite(BASE + 32'h24, 32'h0, 4'hF, ok);
        startCount = validCount;
        wbWrite(BASE + 32'h1C, 32'h1001, 4'hF, ok);
        checks++;
        if (fpuValid !== 1'b1 || fpuA !== 32'h3F80_0000 || fpuB !== 32'h4000_0000 || fpuOp !== 12'h001) begin
            errors++;
            $display("[TB] FAIL add_issue: valid=%b a=%h b=%h op=%h, required 1 3f800000 40000000 001",
                     fpuValid, fpuA, fpuB, fpuOp);
        end
        @(negedge clk);
        checks++;
        if (fpuValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_valid_pulse: valid=%b in WAIT, required 0", fpuValid);
        end
        repeat (4) @(negedge clk);
        fpuResult = 32'h4040_0000;
        fpuFlags  = 5'd0;
        fpuDone   = 1'b1;
        @(negedge clk);
        fpuDone = 1'b0;
        wbRead(BASE + 32'h0C, rd, ok);
        checks++;
        if (!ok || rd !== 32'h4040_0000) begin
            errors++;
            $display("[TB] FAIL add_result: ack=%b data=%h, required 40400000", ok, rd);
        end
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL add_status: ack=%b data=%h, required 2", ok, rd);
        end
        checks++;
        if (validCount - startCount !== 1 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_pulses: pulses=%0d irq=%b, required 1 and 0",
                     validCount - startCount, irq);
        end
    endtask

    task automatic test_timeout();
        logic        ok;
        logic [31:0] rd;
        wbWrite(BASE + 32'h18, 32'h1, 4'hF, ok);
        wbWrite(BASE + 32'h1C, 32'h1001, 4'hF, ok);
        // Now in ISSUE; WAIT begins at the next edge and timeout lands 64 edges after that.
        repeat (64) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: irq=%b one cycle before timeout, required 0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_irq: irq=%b, required 1", irq);
        end
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h4) begin
            errors++;
            $display("[TB] FAIL timeout_status: ack=%b data=%h, required 4", ok, rd);
        end
        wbRead(BASE + 32'h0C, rd, ok);
        checks++;
        if (!ok || rd !== 32'h4040_0000) begin
            errors++;
            $display("[TB] FAIL timeout_result_kept: data=%h, required 40400000", rd);
        end
        wbWrite(BASE + 32'h18, 32'h3, 4'hF, ok);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1c_irq: irq=%b, required 0", irq);
        end
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL w1c_status: data=%h, required 0", rd);
        end
        wbRead(BASE + 32'h18, rd, ok);
        checks++;
        if (!ok || rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL ctrl_readback: data=%h, required 1", rd);
        end
    endtask

    task automatic test_busy_writes();
        logic        ok1, ok2, ok;
        logic [31:0] rd;
        int          startCount;
        wbWrite(BASE + 32'h18, 32'h0, 4'hF, ok);
        startCount = validCount;
        wbWrite(BASE + 32'h1C, 32'h1001, 4'hF, ok);
        wbWrite(BASE + 32'h00, 32'hDEAD_BEEF, 4'hF, ok1);
        wbWrite(BASE + 32'h1C, 32'h1002, 4'hF, ok2);
        checks++;
        if (!ok1 || !ok2) begin
            errors++;
            $display("[TB] FAIL busy_ack: ackA=%b ackOp=%b, required 1 1", ok1, ok2);
        end
        wbRead(BASE + 32'h00, rd, ok);
        checks++;
        if (!ok || rd !== 32'h3F80_0000) begin
            errors++;
            $display("[TB] FAIL busy_a_kept: data=%h, required 3f800000", rd);
        end
        wbRead(BASE + 32'h1C, rd, ok);
        checks++;
        if (!ok || rd !== 32'h001) begin
            errors++;
            $display("[TB] FAIL busy_op_kept: data=%h, required 1", rd);
        end
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL busy_status: data=%h, required 1", rd);
        end
        fpuResult = 32'h1234_5678;
        fpuFlags  = 5'h11;
        fpuDone   = 1'b1;
        @(negedge clk);
        fpuDone = 1'b0;
        wbRead(BASE + 32'h10, rd, ok);
        checks++;
        if (!ok || rd !== 32'h11) begin
            errors++;
            $display("[TB] FAIL busy_flags: data=%h, required 11", rd);
        end
        checks++;
        if (validCount - startCount !== 1) begin
            errors++;
            $display("[TB] FAIL busy_pulses: pulses=%0d, required 1", validCount - startCount);
        end
    endtask

    task automatic test_races();
        logic        ok;
        logic [31:0] rd;
        wbWrite(BASE + 32'h1C, 32'h1001, 4'hF, ok);
        repeat (2) @(negedge clk);
        fpuResult = 32'h1111_1111;
        fpuFlags  = 5'h02;
        fpuDone   = 1'b1;
        wbWrite(BASE + 32'h18, 32'h2, 4'hF, ok);
        fpuDone = 1'b0;
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL w1c_race_status: data=%h, required 2", rd);
        end
        wbWrite(BASE + 32'h1C, 32'h1001, 4'hF, ok);
        fpuResult = 32'hAAAA_AAAA;
        fpuDone   = 1'b1;
        @(negedge clk);
        fpuDone = 1'b0;
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL issue_done_status: data=%h, required 1", rd);
        end
        wbRead(BASE + 32'h0C, rd, ok);
        checks++;
        if (!ok || rd !== 32'h1111_1111) begin
            errors++;
            $display("[TB] FAIL issue_done_result: data=%h, required 11111111", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic        ok;
        logic [31:0] rd;
        rstL = 1'b0;
        @(negedge clk);
        rstL = 1'b1;
        checks++;
        if (fpuValid !== 1'b0 || irq !== 1'b0 || fpuA !== 32'd0 || fpuOp !== 12'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: valid=%b irq=%b a=%h op=%h, required all 0",
                     fpuValid, irq, fpuA, fpuOp);
        end
        fpuResult = 32'h5555_5555;
        fpuFlags  = 5'h1F;
        fpuDone   = 1'b1;
        @(negedge clk);
        fpuDone = 1'b0;
        wbRead(BASE + 32'h14, rd, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_status: data=%h, required 0", rd);
        end
        wbRead(BASE + 32'h0C, rd, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_result: data=%h, required 0", rd);
        end
        wbRead(BASE + 32'h10, rd, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: data=%h, required 0", rd);
        end
    endtask

    task automatic test_byte_enables();
        logic        ok;
        logic [31:0] rd;
        wbWrite(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, ok);
        wbWrite(BASE + 32'h00, 32'h1234_5678, 4'b0010, ok);
        wbRead(BASE + 32'h00, rd, ok);
        checks++;
        if (!ok || rd !== 32'hFFFF_56FF) begin
            errors++;
            $display("[TB] FAIL byte_enable_a: data=%h, required ffff56ff", rd);
        end
        wbWrite(BASE + 32'h24, 32'h0000_0007, 4'hF, ok);
        wbWrite(BASE + 32'h1C, 32'h0000_0ABC, 4'b0001, ok);
        checks++;
        if (fpuRm !== 3'd7 || fpuOp !== 12'h0BC || fpuValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_enable_op: rm=%h op=%h valid=%b, required 7 0bc 0",
                     fpuRm, fpuOp, fpuValid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstL         = 1'b0;
        fpuResult    = 32'd0;
        fpuFlags     = 5'd0;
        fpuDone      = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'd0;
        wb.wbs_dat_i = 32'd0;
        @(negedge clk);
        test_reset();
        test_add();
        test_timeout();
        test_busy_writes();
        test_races();
        test_reset_mid();
        test_byte_enables();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
